// File: rtl/down5bit_counter.sv
// 5-bit down counter with parallel load, wrap-or-saturate at zero, and
// registered zero / borrow flags derived from the next count value.
module down5bit_counter #(
    parameter logic [4:0]  RELOAD_VAL = 5'd31,
    parameter int unsigned SATURATE   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic [4:0] load_val,
    output logic [4:0] out,
    output logic       zero,
    output logic       borrow
);

    localparam int unsigned CW = 5;

    logic [CW-1:0] out_d, out_q;
    logic          zero_d, zero_q;
    logic          borrow_d, borrow_q;

    // Next count: load beats enable; at zero either reload (with borrow) or hold.
    always_comb begin
        out_d    = out_q;
        borrow_d = 1'b0;
        if (load) begin
            out_d = load_val;
        end else if (en) begin
            if (out_q != '0) begin
                out_d = CW'(out_q - CW'(1));
            end else if (SATURATE == 0) begin
                out_d    = RELOAD_VAL;
                borrow_d = 1'b1;
            end
        end
        zero_d = (out_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q    <= RELOAD_VAL;
            zero_q   <= (RELOAD_VAL == '0);
            borrow_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            zero_q   <= zero_d;
            borrow_q <= borrow_d;
        end
    end

    assign out    = out_q;
    assign zero   = zero_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_down5bit_counter.sv
// Scoreboard bench: a wrapping and a saturating counter share one stimulus
// stream; expected outputs come from an integer reference model.
module tb_down5bit_counter;

    localparam int RELOAD = 31;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [4:0] load_val;
    logic [4:0] out_w, out_s;
    logic       zero_w, zero_s;
    logic       borrow_w, borrow_s;

    down5bit_counter #(.RELOAD_VAL(5'd31), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .out(out_w), .zero(zero_w), .borrow(borrow_w)
    );

    down5bit_counter #(.RELOAD_VAL(5'd31), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .out(out_s), .zero(zero_s), .borrow(borrow_s)
    );

    typedef struct {
        int cyc;
        int w_out;
        int w_zero;
        int w_borrow;
        int s_out;
        int s_zero;
        int s_borrow;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   mw    = RELOAD;
    int   ms    = RELOAD;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int cnum, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cnum, act, exp);
        end
    endtask

    // Reference rule for one clock edge, written from the behavioural description.
    function automatic void model_next(input int cur, input bit e, input bit l, input int v,
                                       input bit sat, output int nxt, output int brw);
        brw = 0;
        if (l)             nxt = v;
        else if (!e)       nxt = cur;
        else if (cur > 0)  nxt = cur - 1;
        else if (sat)      nxt = 0;
        else begin
            nxt = RELOAD;
            brw = 1;
        end
    endfunction

    task automatic step(input bit r, input bit e, input bit l, input int v);
        exp_t x;
        int   bw, bs, nw, ns;
        @(negedge clk);
        reset    = r;
        en       = e;
        load     = l;
        load_val = 5'(v);
        if (r) begin
            nw = RELOAD; bw = 0;
            ns = RELOAD; bs = 0;
        end else begin
            model_next(mw, e, l, v, 1'b0, nw, bw);
            model_next(ms, e, l, v, 1'b1, ns, bs);
        end
        mw = nw;
        ms = ns;
        cyc++;
        x.cyc      = cyc;
        x.w_out    = mw;
        x.w_zero   = (mw == 0) ? 1 : 0;
        x.w_borrow = bw;
        x.s_out    = ms;
        x.s_zero   = (ms == 0) ? 1 : 0;
        x.s_borrow = bs;
        sb.push_back(x);
    endtask

    task automatic check_now(input string tag);
        chk({tag, "_out_w"},    cyc, int'(out_w),    RELOAD);
        chk({tag, "_zero_w"},   cyc, int'(zero_w),   0);
        chk({tag, "_borrow_w"}, cyc, int'(borrow_w), 0);
        chk({tag, "_out_s"},    cyc, int'(out_s),    RELOAD);
        chk({tag, "_borrow_s"}, cyc, int'(borrow_s), 0);
    endtask

    // Monitor: one expected entry retires per clock edge, sampled after the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("out_w",    x.cyc, int'(out_w),    x.w_out);
                chk("zero_w",   x.cyc, int'(zero_w),   x.w_zero);
                chk("borrow_w", x.cyc, int'(borrow_w), x.w_borrow);
                chk("out_s",    x.cyc, int'(out_s),    x.s_out);
                chk("zero_s",   x.cyc, int'(zero_s),   x.s_zero);
                chk("borrow_s", x.cyc, int'(borrow_s), x.s_borrow);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        load_val = 5'd0;
        #2;
        check_now("reset_async");

        // Reset held, then released with enable low for three edges.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        // Full count through zero, wrap, and one more decrement.
        for (int i = 0; i < 33; i++) step(0, 1, 0, 0);

        // Load 5 and count down through a single wrap.
        step(0, 1, 1, 5);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);

        // Load 2 and keep counting: saturating instance sticks at zero.
        step(0, 1, 1, 2);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

        // Count to 17, then assert reset between edges.
        step(0, 1, 1, 20);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_now("reset_mid");
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

        // Load while sitting at zero with enable high: load wins, no borrow.
        step(0, 1, 1, 1);
        step(0, 1, 0, 0);
        step(0, 1, 1, 9);
        step(0, 1, 0, 0);

        // Randomized traffic including occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 31)));
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) chk("drain", cyc, sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
